// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//
// Responder side of the instruction-fetch interface. The fetch stage presents
// a byte PC on addr together with rd. The word is read from an internal array
// and returned with a fixed latency. stall is high while a read is
// outstanding, and done pulses for one cycle when the word is returned. flush
// squashes an outstanding read, for example when a branch redirects the PC. A
// single-cycle write port preloads the program.
//
// Parameters
//   LATENCY  cycles from the accepting edge to the done cycle (1..15)
//   MEM_AW   word-address width; the array holds 2**MEM_AW 16-bit words
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   rd        fetch read request, only looked at while idle
//   addr      byte address; the word index is addr[MEM_AW:1]
//   flush     squash the outstanding or presented read
//   wr        preload write strobe
//   wdata     preload write data
//   stall     high while a read is outstanding (BUSY)
//   done      one-cycle pulse, data_out/err valid
//   data_out  returned instruction word, held until the next done
//   err       misaligned request flag, valid with done
// -----------------------------------------------------------------------------
module imem_responder #(
  parameter int LATENCY = 4,
  parameter int MEM_AW  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic [15:0] addr,
  input  logic        flush,
  input  logic        wr,
  input  logic [15:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [15:0] data_out,
  output logic        err
);

  localparam int DEPTH = 1 << MEM_AW;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // The counter is loaded at acceptance and the read completes on the edge
  // where it reads 1. That edge places done exactly LATENCY cycles after
  // the accepting edge.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
  localparam bit         SINGLE   = (LATENCY == 1);

  logic [15:0]       mem [DEPTH];
  logic [0:0]        state;
  logic [3:0]        cnt;
  logic [MEM_AW-1:0] lat_word;
  logic [MEM_AW-1:0] req_word;

  logic in_idle;
  logic do_write;
  logic do_misalign;
  logic do_accept;

  // Address bits above MEM_AW alias onto the array and are deliberately
  // ignored. Bit 0 only selects the misaligned path.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, addr};

  assign req_word = addr[MEM_AW:1];
  assign in_idle  = (state == ST_IDLE);
  assign stall    = (state == ST_BUSY);

  // In idle the inputs are decoded in priority order: flush, then write,
  // then read. A read presented together with a write is dropped. The
  // fetch side must present the read again.
  always_comb begin
    do_write    = 1'b0;
    do_misalign = 1'b0;
    do_accept   = 1'b0;
    if (in_idle && !flush) begin
      if (wr) begin
        do_write = 1'b1;
      end else if (rd) begin
        do_misalign = addr[0];
        do_accept   = !addr[0];
      end
    end
  end

  // The array has no reset, so its contents survive rst.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[req_word] <= wdata;
    end
  end

  // Control and returned data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      lat_word <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      data_out <= 16'h0000;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (do_misalign) begin
            done     <= 1'b1;
            err      <= 1'b1;
            data_out <= 16'h0000;
          end else if (do_accept) begin
            lat_word <= req_word;
            cnt      <= CNT_LOAD;
            if (SINGLE) begin
              // The whole latency fits in the accepting edge, so the
              // responder never enters BUSY.
              done     <= 1'b1;
              data_out <= mem[req_word];
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (flush) begin
            // The read is squashed: no done is issued and data_out keeps
            // the word from the previous read.
            state <= ST_IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state    <= ST_IDLE;
              done     <= 1'b1;
              data_out <= mem[lat_word];
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
//
// Drives a LATENCY=4 responder and a LATENCY=1 responder from one directed
// sequence, followed by a randomized phase. Expected words come from a plain
// word-array model indexed by (byte address / 2) modulo the array depth.
// -----------------------------------------------------------------------------
module tb_imem_responder;

  localparam int L     = 4;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd, flush, wr;
  logic [15:0] addr, wdata;
  logic        stall, done, err;
  logic [15:0] data_out;

  logic        rd1, flush1, wr1;
  logic [15:0] addr1, wdata1;
  logic        stall1, done1, err1;
  logic [15:0] data1;

  int checks = 0;
  int errors = 0;
  int stall1_hi = 0;

  logic [15:0] model_mem [DEPTH];

  imem_responder #(.LATENCY(L), .MEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .rd(rd), .addr(addr), .flush(flush), .wr(wr),
    .wdata(wdata), .stall(stall), .done(done), .data_out(data_out), .err(err)
  );

  imem_responder #(.LATENCY(1), .MEM_AW(AW)) dut1 (
    .clk(clk), .rst(rst), .rd(rd1), .addr(addr1), .flush(flush1), .wr(wr1),
    .wdata(wdata1), .stall(stall1), .done(done1), .data_out(data1), .err(err1)
  );

  always @(negedge clk) begin
    if (rst && stall1) stall1_hi++;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(input logic [15:0] a);
    return (int'(a) / 2) % DEPTH;
  endfunction

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    wr = 1'b1; rd = 1'b0; addr = a; wdata = d;
    tick();
    wr = 1'b0;
    chk1("wr_no_done", done, 1'b0);
    chk1("wr_no_stall", stall, 1'b0);
    model_mem[widx(a)] = d;
  endtask

  // Called in an idle cycle. Leaves the DUT in its done cycle with rd still
  // high unless release_rd is set, so the next call chains back-to-back.
  task automatic do_read(input logic [15:0] a, input bit release_rd);
    rd = 1'b1; addr = a; wr = 1'b0; flush = 1'b0;
    tick();
    if (a[0]) begin
      chk1("mis_done", done, 1'b1);
      chk1("mis_err", err, 1'b1);
      chk16("mis_data", data_out, 16'h0000);
      chk1("mis_stall", stall, 1'b0);
    end else begin
      for (int i = 1; i < L; i++) begin
        chk1("busy_stall", stall, 1'b1);
        chk1("busy_done", done, 1'b0);
        tick();
      end
      chk1("rd_done", done, 1'b1);
      chk1("rd_err", err, 1'b0);
      chk1("rd_stall", stall, 1'b0);
      chk16("rd_data", data_out, model_mem[widx(a)]);
    end
    if (release_rd) rd = 1'b0;
  endtask

  // An aligned read is accepted, then flushed in BUSY cycle k (1..L-1).
  task automatic flushed_read(input logic [15:0] a, input int k);
    logic [15:0] old;
    old = data_out;
    rd = 1'b1; addr = a;
    tick();
    chk1("fl_busy", stall, 1'b1);
    for (int j = 1; j < k; j++) tick();
    flush = 1'b1; rd = 1'b0;
    tick();
    flush = 1'b0;
    chk1("fl_stall_drop", stall, 1'b0);
    chk1("fl_no_done", done, 1'b0);
    chk16("fl_data_hold", data_out, old);
    for (int j = 0; j < L; j++) begin
      tick();
      chk1("fl_quiet", done, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] a;
    int          idx;
    int          op;

    rst = 1'b0;
    rd = 1'b0; flush = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    rd1 = 1'b0; flush1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    tick();
    tick();
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk16("rst_data", data_out, 16'h0000);
    chk1("rst1_done", done1, 1'b0);
    chk16("rst1_data", data1, 16'h0000);
    rst = 1'b1;
    tick();

    // Basic read with the result held afterwards
    do_write(16'h0004, 16'hA5C3);
    do_read(16'h0004, 1'b1);
    tick();
    chk1("hold_done", done, 1'b0);
    chk16("hold_data", data_out, 16'hA5C3);

    // Back-to-back reads, one every L cycles
    do_write(16'h0000, 16'h1111);
    do_write(16'h0002, 16'h2222);
    do_write(16'h0004, 16'h3333);
    do_write(16'h0006, 16'h4444);
    do_read(16'h0000, 1'b0);
    do_read(16'h0002, 1'b0);
    do_read(16'h0004, 1'b0);
    do_read(16'h0006, 1'b1);
    tick();

    // Flush two cycles after acceptance, then a fresh read
    flushed_read(16'h0006, 2);
    do_read(16'h0000, 1'b1);
    tick();

    // Misaligned request
    do_read(16'h0003, 1'b1);
    tick();
    chk1("mis_after_done", done, 1'b0);
    chk1("mis_after_err", err, 1'b0);
    chk1("mis_after_stall", stall, 1'b0);

    // A write beats a read in the same cycle; the write address aliases word 1
    wr = 1'b1; rd = 1'b1; addr = 16'h0802; wdata = 16'hBEEF;
    tick();
    wr = 1'b0; rd = 1'b0;
    chk1("prio_no_done", done, 1'b0);
    chk1("prio_no_stall", stall, 1'b0);
    tick();
    chk1("prio_no_done2", done, 1'b0);
    model_mem[1] = 16'hBEEF;
    do_read(16'h0002, 1'b1);
    tick();

    // Flush in idle blocks both a write and a read
    do_write(16'h000A, 16'h5555);
    flush = 1'b1; wr = 1'b1; addr = 16'h000A; wdata = 16'hDEAD;
    tick();
    wr = 1'b0; rd = 1'b1; addr = 16'h0000;
    tick();
    flush = 1'b0; rd = 1'b0;
    chk1("idle_flush_stall", stall, 1'b0);
    tick();
    chk1("idle_flush_done", done, 1'b0);
    do_read(16'h000A, 1'b1);
    tick();

    // Asynchronous reset in the middle of a read
    do_write(16'h0012, 16'h1234);
    do_read(16'h0004, 1'b1);
    rd = 1'b1; addr = 16'h0012;
    tick();
    tick();
    #2;
    rst = 1'b0; rd = 1'b0;
    #1;
    chk1("arst_stall", stall, 1'b0);
    chk1("arst_done", done, 1'b0);
    chk16("arst_data", data_out, 16'h0000);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < L + 2; i++) begin
      tick();
      chk1("arst_no_done", done, 1'b0);
      chk1("arst_no_stall", stall, 1'b0);
    end
    do_read(16'h0012, 1'b1);
    tick();

    // Randomized phase
    for (int i = 0; i < 32; i++) begin
      a = 16'($urandom);
      a[AW:1] = 10'(i);
      a[0] = 1'b0;
      do_write(a, 16'($urandom));
    end
    for (int n = 0; n < 60; n++) begin
      op  = $urandom_range(0, 4);
      idx = $urandom_range(0, 31);
      a = 16'($urandom);
      a[AW:1] = 10'(idx);
      case (op)
        0: begin
          a[0] = 1'b0;
          do_write(a, 16'($urandom));
        end
        1: begin
          a[0] = 1'b0;
          flushed_read(a, $urandom_range(1, L - 1));
        end
        2: begin
          a[0] = 1'b1;
          do_read(a, 1'b1);
        end
        default: begin
          a[0] = 1'b0;
          do_read(a, ($urandom_range(0, 1) == 1));
        end
      endcase
    end
    rd = 1'b0;
    tick();

    // LATENCY=1 responder
    wr1 = 1'b1; addr1 = 16'h0006; wdata1 = 16'h7E57;
    tick();
    addr1 = 16'h0008; wdata1 = 16'h0444;
    tick();
    wr1 = 1'b0; rd1 = 1'b1; addr1 = 16'h0006;
    tick();
    chk1("l1_done", done1, 1'b1);
    chk1("l1_err", err1, 1'b0);
    chk16("l1_data", data1, 16'h7E57);
    addr1 = 16'h0008;
    tick();
    chk1("l1_b2b_done", done1, 1'b1);
    chk16("l1_b2b_data", data1, 16'h0444);
    rd1 = 1'b0;
    tick();
    chk1("l1_quiet", done1, 1'b0);
    chk16("l1_hold", data1, 16'h0444);
    rd1 = 1'b1; addr1 = 16'h0005;
    tick();
    rd1 = 1'b0;
    chk1("l1_mis_done", done1, 1'b1);
    chk1("l1_mis_err", err1, 1'b1);
    chk16("l1_mis_data", data1, 16'h0000);
    tick();
    chk1("l1_stall_never", (stall1_hi != 0), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
